// File: rtl/id_stage.sv
// id_stage: instruction decode with operand forwarding, load-use/RAW hazard
// detection and a single ID/EX pipeline register with valid/ready handshake.
module id_stage #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned REG_AW   = 5,
    parameter int unsigned FWD_EN   = 1,
    localparam int unsigned ALUOP_W  = 8,
    localparam int unsigned ALUSEL_W = 3
) (
    input  logic                clk,
    input  logic                rst,

    input  logic                inst_valid_i,
    input  logic [31:0]         inst_i,
    output logic                id_ready_o,

    output logic                reg1_read_o,
    output logic                reg2_read_o,
    output logic [REG_AW-1:0]   reg1_addr_o,
    output logic [REG_AW-1:0]   reg2_addr_o,
    input  logic [DATA_W-1:0]   reg1_data_i,
    input  logic [DATA_W-1:0]   reg2_data_i,

    input  logic                ex_wreg_i,
    input  logic [REG_AW-1:0]   ex_wd_i,
    input  logic [DATA_W-1:0]   ex_wdata_i,
    input  logic                ex_is_load_i,

    input  logic                mem_wreg_i,
    input  logic [REG_AW-1:0]   mem_wd_i,
    input  logic [DATA_W-1:0]   mem_wdata_i,

    input  logic                flush_i,
    input  logic                ex_ready_i,

    output logic                ex_valid_o,
    output logic [ALUOP_W-1:0]  aluop_o,
    output logic [ALUSEL_W-1:0] alusel_o,
    output logic [DATA_W-1:0]   reg1_o,
    output logic [DATA_W-1:0]   reg2_o,
    output logic [REG_AW-1:0]   wd_o,
    output logic                wreg_o,
    output logic                instvalid_o
);

    // Primary opcodes
    localparam logic [5:0] OP_SPECIAL = 6'b000000;
    localparam logic [5:0] OP_ANDI    = 6'b001100;
    localparam logic [5:0] OP_ORI     = 6'b001101;
    localparam logic [5:0] OP_XORI    = 6'b001110;
    localparam logic [5:0] OP_LUI     = 6'b001111;

    // SPECIAL function codes
    localparam logic [5:0] FN_SLL = 6'b000000;
    localparam logic [5:0] FN_SRL = 6'b000010;
    localparam logic [5:0] FN_SRA = 6'b000011;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_XOR = 6'b100110;
    localparam logic [5:0] FN_NOR = 6'b100111;

    // ALU operation codes
    localparam logic [ALUOP_W-1:0] ALUOP_NOP = 8'b0000_0000;
    localparam logic [ALUOP_W-1:0] ALUOP_AND = 8'b0010_0100;
    localparam logic [ALUOP_W-1:0] ALUOP_OR  = 8'b0010_0101;
    localparam logic [ALUOP_W-1:0] ALUOP_XOR = 8'b0010_0110;
    localparam logic [ALUOP_W-1:0] ALUOP_NOR = 8'b0010_0111;
    localparam logic [ALUOP_W-1:0] ALUOP_SLL = 8'b0111_1100;
    localparam logic [ALUOP_W-1:0] ALUOP_SRL = 8'b0000_0010;
    localparam logic [ALUOP_W-1:0] ALUOP_SRA = 8'b0000_0011;

    // Result select codes
    localparam logic [ALUSEL_W-1:0] ALUSEL_NOP   = 3'b000;
    localparam logic [ALUSEL_W-1:0] ALUSEL_LOGIC = 3'b001;
    localparam logic [ALUSEL_W-1:0] ALUSEL_SHIFT = 3'b010;

    // Instruction fields
    logic [5:0]        op;
    logic [5:0]        funct;
    logic [REG_AW-1:0] rs_addr;
    logic [REG_AW-1:0] rt_addr;
    logic [REG_AW-1:0] rd_addr;

    // Decoded entry
    logic                dec_re1;
    logic                dec_re2;
    logic [DATA_W-1:0]   dec_imm1;
    logic [DATA_W-1:0]   dec_imm2;
    logic [ALUOP_W-1:0]  dec_aluop;
    logic [ALUSEL_W-1:0] dec_alusel;
    logic [REG_AW-1:0]   dec_wd;
    logic                dec_wreg;
    logic                dec_instvalid;

    // Resolved operands and control
    logic [DATA_W-1:0] opnd1;
    logic [DATA_W-1:0] opnd2;
    logic              src1_live;
    logic              src2_live;
    logic              load_hazard;
    logic              raw_hazard;
    logic              hazard;
    logic              advance;
    logic              accept;
    logic              fwd_off;

    // Next values of the ID/EX register
    logic                nxt_valid;
    logic [ALUOP_W-1:0]  nxt_aluop;
    logic [ALUSEL_W-1:0] nxt_alusel;
    logic [DATA_W-1:0]   nxt_reg1;
    logic [DATA_W-1:0]   nxt_reg2;
    logic [REG_AW-1:0]   nxt_wd;
    logic                nxt_wreg;
    logic                nxt_instvalid;

    assign op      = inst_i[31:26];
    assign funct   = inst_i[5:0];
    assign rs_addr = REG_AW'(inst_i[25:21]);
    assign rt_addr = REG_AW'(inst_i[20:16]);
    assign rd_addr = REG_AW'(inst_i[15:11]);
    assign fwd_off = (FWD_EN == 0);

    // Instruction decode: read enables, immediates, operation and destination
    always_comb begin
        dec_re1       = 1'b0;
        dec_re2       = 1'b0;
        dec_imm1      = '0;
        dec_imm2      = '0;
        dec_aluop     = ALUOP_NOP;
        dec_alusel    = ALUSEL_NOP;
        dec_wd        = '0;
        dec_wreg      = 1'b0;
        dec_instvalid = 1'b0;
        unique case (op)
            OP_SPECIAL: begin
                if (inst_i == 32'h0000_0000) begin
                    // canonical NOP (would otherwise decode as SLL $0)
                    dec_instvalid = 1'b1;
                end else begin
                    unique case (funct)
                        FN_OR, FN_AND, FN_XOR, FN_NOR: begin
                            dec_re1       = 1'b1;
                            dec_re2       = 1'b1;
                            dec_wd        = rd_addr;
                            dec_wreg      = 1'b1;
                            dec_alusel    = ALUSEL_LOGIC;
                            dec_instvalid = 1'b1;
                            unique case (funct)
                                FN_OR:   dec_aluop = ALUOP_OR;
                                FN_AND:  dec_aluop = ALUOP_AND;
                                FN_XOR:  dec_aluop = ALUOP_XOR;
                                default: dec_aluop = ALUOP_NOR;
                            endcase
                        end
                        FN_SLL, FN_SRL, FN_SRA: begin
                            dec_re2       = 1'b1;
                            dec_imm1      = DATA_W'(inst_i[10:6]);
                            dec_wd        = rd_addr;
                            dec_wreg      = 1'b1;
                            dec_alusel    = ALUSEL_SHIFT;
                            dec_instvalid = 1'b1;
                            unique case (funct)
                                FN_SLL:  dec_aluop = ALUOP_SLL;
                                FN_SRL:  dec_aluop = ALUOP_SRL;
                                default: dec_aluop = ALUOP_SRA;
                            endcase
                        end
                        default: ;
                    endcase
                end
            end
            OP_ORI, OP_ANDI, OP_XORI: begin
                dec_re1       = 1'b1;
                dec_imm2      = DATA_W'(inst_i[15:0]);
                dec_wd        = rt_addr;
                dec_wreg      = 1'b1;
                dec_alusel    = ALUSEL_LOGIC;
                dec_instvalid = 1'b1;
                unique case (op)
                    OP_ORI:  dec_aluop = ALUOP_OR;
                    OP_ANDI: dec_aluop = ALUOP_AND;
                    default: dec_aluop = ALUOP_XOR;
                endcase
            end
            OP_LUI: begin
                // OR of zero with the shifted immediate; rs is not read
                dec_imm2      = DATA_W'({inst_i[15:0], 16'h0000});
                dec_wd        = rt_addr;
                dec_wreg      = 1'b1;
                dec_aluop     = ALUOP_OR;
                dec_alusel    = ALUSEL_LOGIC;
                dec_instvalid = 1'b1;
            end
            default: ;
        endcase
    end

    // Operand 1 select: immediate, $0, EX forward, MEM forward, register file
    always_comb begin
        opnd1 = reg1_data_i;
        if (!dec_re1) begin
            opnd1 = dec_imm1;
        end else if (rs_addr == '0) begin
            opnd1 = '0;
        end else if (ex_wreg_i && (ex_wd_i == rs_addr) && !ex_is_load_i) begin
            opnd1 = ex_wdata_i;
        end else if (mem_wreg_i && (mem_wd_i == rs_addr)) begin
            opnd1 = mem_wdata_i;
        end
    end

    // Operand 2 select: same priority as operand 1, on rt
    always_comb begin
        opnd2 = reg2_data_i;
        if (!dec_re2) begin
            opnd2 = dec_imm2;
        end else if (rt_addr == '0) begin
            opnd2 = '0;
        end else if (ex_wreg_i && (ex_wd_i == rt_addr) && !ex_is_load_i) begin
            opnd2 = ex_wdata_i;
        end else if (mem_wreg_i && (mem_wd_i == rt_addr)) begin
            opnd2 = mem_wdata_i;
        end
    end

    // Hazard detection: load-use always, any RAW match when forwarding is off
    always_comb begin
        src1_live   = dec_re1 && (rs_addr != '0);
        src2_live   = dec_re2 && (rt_addr != '0);
        load_hazard = ex_wreg_i && ex_is_load_i &&
                      ((src1_live && (ex_wd_i == rs_addr)) ||
                       (src2_live && (ex_wd_i == rt_addr)));
        raw_hazard  = fwd_off &&
                      ((ex_wreg_i  && ((src1_live && (ex_wd_i  == rs_addr)) ||
                                       (src2_live && (ex_wd_i  == rt_addr)))) ||
                       (mem_wreg_i && ((src1_live && (mem_wd_i == rs_addr)) ||
                                       (src2_live && (mem_wd_i == rt_addr)))));
        hazard      = load_hazard || raw_hazard;
    end

    assign advance     = ex_ready_i || !ex_valid_o;
    assign id_ready_o  = advance && !hazard;
    assign accept      = inst_valid_i && id_ready_o;
    assign reg1_read_o = dec_re1;
    assign reg2_read_o = dec_re2;
    assign reg1_addr_o = rs_addr;
    assign reg2_addr_o = rt_addr;

    // ID/EX next value: flush and idle slots load a bubble, stalls hold
    always_comb begin
        nxt_valid     = ex_valid_o;
        nxt_aluop     = aluop_o;
        nxt_alusel    = alusel_o;
        nxt_reg1      = reg1_o;
        nxt_reg2      = reg2_o;
        nxt_wd        = wd_o;
        nxt_wreg      = wreg_o;
        nxt_instvalid = instvalid_o;
        if (flush_i || (advance && !accept)) begin
            nxt_valid     = 1'b0;
            nxt_aluop     = ALUOP_NOP;
            nxt_alusel    = ALUSEL_NOP;
            nxt_reg1      = '0;
            nxt_reg2      = '0;
            nxt_wd        = '0;
            nxt_wreg      = 1'b0;
            nxt_instvalid = 1'b0;
        end else if (accept) begin
            nxt_valid     = 1'b1;
            nxt_aluop     = dec_aluop;
            nxt_alusel    = dec_alusel;
            nxt_reg1      = opnd1;
            nxt_reg2      = opnd2;
            nxt_wd        = dec_wd;
            nxt_wreg      = dec_wreg;
            nxt_instvalid = dec_instvalid;
        end
    end

    // ID/EX register with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            ex_valid_o  <= 1'b0;
            aluop_o     <= ALUOP_NOP;
            alusel_o    <= ALUSEL_NOP;
            reg1_o      <= '0;
            reg2_o      <= '0;
            wd_o        <= '0;
            wreg_o      <= 1'b0;
            instvalid_o <= 1'b0;
        end else begin
            ex_valid_o  <= nxt_valid;
            aluop_o     <= nxt_aluop;
            alusel_o    <= nxt_alusel;
            reg1_o      <= nxt_reg1;
            reg2_o      <= nxt_reg2;
            wd_o        <= nxt_wd;
            wreg_o      <= nxt_wreg;
            instvalid_o <= nxt_instvalid;
        end
    end

endmodule

// File: tb/tb_id_stage.sv
// tb_id_stage: directed checks of decode, forwarding, hazards, hold, flush, reset.
module tb_id_stage;

    logic        clk;
    logic        rst;
    logic        inst_valid_i;
    logic [31:0] inst_i;
    logic [31:0] reg1_data_i, reg2_data_i;
    logic        ex_wreg_i, ex_is_load_i;
    logic [4:0]  ex_wd_i;
    logic [31:0] ex_wdata_i;
    logic        mem_wreg_i;
    logic [4:0]  mem_wd_i;
    logic [31:0] mem_wdata_i;
    logic        flush_i, ex_ready_i;

    // forwarding instance outputs
    logic        a_id_ready, a_re1, a_re2, a_ex_valid, a_wreg, a_instvalid;
    logic [4:0]  a_addr1, a_addr2, a_wd;
    logic [7:0]  a_aluop;
    logic [2:0]  a_alusel;
    logic [31:0] a_reg1, a_reg2;

    // no-forwarding instance outputs
    logic        b_id_ready, b_re1, b_re2, b_ex_valid, b_wreg, b_instvalid;
    logic [4:0]  b_addr1, b_addr2, b_wd;
    logic [7:0]  b_aluop;
    logic [2:0]  b_alusel;
    logic [31:0] b_reg1, b_reg2;

    int checks = 0;
    int errors = 0;

    id_stage #(.DATA_W(32), .REG_AW(5), .FWD_EN(1)) u_fwd (
        .clk(clk), .rst(rst), .inst_valid_i(inst_valid_i), .inst_i(inst_i),
        .id_ready_o(a_id_ready), .reg1_read_o(a_re1), .reg2_read_o(a_re2),
        .reg1_addr_o(a_addr1), .reg2_addr_o(a_addr2),
        .reg1_data_i(reg1_data_i), .reg2_data_i(reg2_data_i),
        .ex_wreg_i(ex_wreg_i), .ex_wd_i(ex_wd_i), .ex_wdata_i(ex_wdata_i),
        .ex_is_load_i(ex_is_load_i),
        .mem_wreg_i(mem_wreg_i), .mem_wd_i(mem_wd_i), .mem_wdata_i(mem_wdata_i),
        .flush_i(flush_i), .ex_ready_i(ex_ready_i),
        .ex_valid_o(a_ex_valid), .aluop_o(a_aluop), .alusel_o(a_alusel),
        .reg1_o(a_reg1), .reg2_o(a_reg2), .wd_o(a_wd), .wreg_o(a_wreg),
        .instvalid_o(a_instvalid)
    );

    id_stage #(.DATA_W(32), .REG_AW(5), .FWD_EN(0)) u_nofwd (
        .clk(clk), .rst(rst), .inst_valid_i(inst_valid_i), .inst_i(inst_i),
        .id_ready_o(b_id_ready), .reg1_read_o(b_re1), .reg2_read_o(b_re2),
        .reg1_addr_o(b_addr1), .reg2_addr_o(b_addr2),
        .reg1_data_i(reg1_data_i), .reg2_data_i(reg2_data_i),
        .ex_wreg_i(ex_wreg_i), .ex_wd_i(ex_wd_i), .ex_wdata_i(ex_wdata_i),
        .ex_is_load_i(ex_is_load_i),
        .mem_wreg_i(mem_wreg_i), .mem_wd_i(mem_wd_i), .mem_wdata_i(mem_wdata_i),
        .flush_i(flush_i), .ex_ready_i(ex_ready_i),
        .ex_valid_o(b_ex_valid), .aluop_o(b_aluop), .alusel_o(b_alusel),
        .reg1_o(b_reg1), .reg2_o(b_reg2), .wd_o(b_wd), .wreg_o(b_wreg),
        .instvalid_o(b_instvalid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // one comparison point
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // advance one edge and settle past it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [4:0] sa,
                                          input logic [5:0] fn);
        return {6'b000000, rs, rt, rd, sa, fn};
    endfunction

    task automatic chk_reset_a(input string tag);
        chk({tag, "_valid"},  32'(a_ex_valid),  32'h0);
        chk({tag, "_aluop"},  32'(a_aluop),     32'h0);
        chk({tag, "_alusel"}, 32'(a_alusel),    32'h0);
        chk({tag, "_reg1"},   a_reg1,           32'h0);
        chk({tag, "_reg2"},   a_reg2,           32'h0);
        chk({tag, "_wd"},     32'(a_wd),        32'h0);
        chk({tag, "_wreg"},   32'(a_wreg),      32'h0);
        chk({tag, "_instv"},  32'(a_instvalid), 32'h0);
    endtask

    initial begin
        rst = 1'b0; inst_valid_i = 1'b0; inst_i = 32'h0;
        reg1_data_i = 32'h0; reg2_data_i = 32'h0;
        ex_wreg_i = 1'b0; ex_wd_i = 5'd0; ex_wdata_i = 32'h0; ex_is_load_i = 1'b0;
        mem_wreg_i = 1'b0; mem_wd_i = 5'd0; mem_wdata_i = 32'h0;
        flush_i = 1'b0; ex_ready_i = 1'b1;
        tick();
        tick();
        chk_reset_a("rst");
        rst = 1'b1;

        // ORI $2,$1,0x00FF
        inst_valid_i = 1'b1;
        inst_i = itype(6'b001101, 5'd1, 5'd2, 16'h00FF);
        reg1_data_i = 32'h1200;
        #1;
        chk("ori_ready", 32'(a_id_ready), 32'h1);
        chk("ori_re1",   32'(a_re1),      32'h1);
        chk("ori_re2",   32'(a_re2),      32'h0);
        chk("ori_addr1", 32'(a_addr1),    32'h1);
        tick();
        chk("ori_valid", 32'(a_ex_valid),  32'h1);
        chk("ori_aluop", 32'(a_aluop),     32'h25);
        chk("ori_sel",   32'(a_alusel),    32'h1);
        chk("ori_reg1",  a_reg1,           32'h1200);
        chk("ori_reg2",  a_reg2,           32'h00FF);
        chk("ori_wd",    32'(a_wd),        32'h2);
        chk("ori_wreg",  32'(a_wreg),      32'h1);
        chk("ori_instv", 32'(a_instvalid), 32'h1);

        // OR $3,$1,$2: EX wins over MEM for $1
        inst_i = rtype(5'd1, 5'd2, 5'd3, 5'd0, 6'h25);
        reg2_data_i = 32'h55;
        ex_wreg_i = 1'b1; ex_wd_i = 5'd1; ex_wdata_i = 32'hA;
        mem_wreg_i = 1'b1; mem_wd_i = 5'd1; mem_wdata_i = 32'hB;
        tick();
        chk("fwd_prio_reg1", a_reg1, 32'hA);
        chk("fwd_prio_reg2", a_reg2, 32'h55);
        chk("fwd_prio_wd",   32'(a_wd), 32'h3);
        // EX $1=0xA, MEM $2=0xC
        mem_wd_i = 5'd2; mem_wdata_i = 32'hC;
        tick();
        chk("fwd_split_reg1", a_reg1, 32'hA);
        chk("fwd_split_reg2", a_reg2, 32'hC);
        // only MEM matches $1
        ex_wd_i = 5'd5; mem_wd_i = 5'd1; mem_wdata_i = 32'hB;
        tick();
        chk("fwd_mem_reg1", a_reg1, 32'hB);
        chk("fwd_mem_reg2", a_reg2, 32'h55);

        // OR $4,$0,$2 with EX writing $0: $0 reads as zero
        inst_i = rtype(5'd0, 5'd2, 5'd4, 5'd0, 6'h25);
        ex_wd_i = 5'd0; ex_wdata_i = 32'h77;
        mem_wreg_i = 1'b0;
        reg1_data_i = 32'h99;
        tick();
        chk("zero_reg1", a_reg1, 32'h0);
        chk("zero_reg2", a_reg2, 32'h55);
        ex_wreg_i = 1'b0;

        // SRA $5,$2,4
        inst_i = rtype(5'd0, 5'd2, 5'd5, 5'd4, 6'h03);
        tick();
        chk("sra_aluop", 32'(a_aluop),  32'h03);
        chk("sra_sel",   32'(a_alusel), 32'h2);
        chk("sra_reg1",  a_reg1,        32'h4);
        chk("sra_reg2",  a_reg2,        32'h55);
        chk("sra_wd",    32'(a_wd),     32'h5);

        // LUI $6,0x1234
        inst_i = itype(6'b001111, 5'd0, 5'd6, 16'h1234);
        #1;
        chk("lui_re1", 32'(a_re1), 32'h0);
        tick();
        chk("lui_aluop", 32'(a_aluop), 32'h25);
        chk("lui_reg1",  a_reg1,       32'h0);
        chk("lui_reg2",  a_reg2,       32'h1234_0000);
        chk("lui_wd",    32'(a_wd),    32'h6);

        // all-zero word is a valid NOP
        inst_i = 32'h0;
        tick();
        chk("nop_valid", 32'(a_ex_valid),  32'h1);
        chk("nop_aluop", 32'(a_aluop),     32'h0);
        chk("nop_wreg",  32'(a_wreg),      32'h0);
        chk("nop_instv", 32'(a_instvalid), 32'h1);

        // load-use hazard on $1
        inst_i = rtype(5'd1, 5'd2, 5'd3, 5'd0, 6'h25);
        ex_wreg_i = 1'b1; ex_is_load_i = 1'b1; ex_wd_i = 5'd1; ex_wdata_i = 32'hDEAD;
        #1;
        chk("lu_ready", 32'(a_id_ready), 32'h0);
        tick();
        chk("lu_bubble_valid", 32'(a_ex_valid), 32'h0);
        chk("lu_bubble_wreg",  32'(a_wreg),     32'h0);
        ex_wreg_i = 1'b0; ex_is_load_i = 1'b0;
        reg1_data_i = 32'h1111; reg2_data_i = 32'h2222;
        #1;
        chk("lu_clear_ready", 32'(a_id_ready), 32'h1);
        tick();
        chk("lu_issue_valid", 32'(a_ex_valid), 32'h1);
        chk("lu_issue_wd",    32'(a_wd),       32'h3);
        chk("lu_issue_reg1",  a_reg1,          32'h1111);

        // downstream backpressure for 3 cycles with a new instruction waiting
        ex_ready_i = 1'b0;
        inst_i = itype(6'b001101, 5'd1, 5'd7, 16'h0001);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("hold_ready", 32'(a_id_ready), 32'h0);
            tick();
            chk("hold_valid", 32'(a_ex_valid), 32'h1);
            chk("hold_wd",    32'(a_wd),       32'h3);
            chk("hold_reg1",  a_reg1,          32'h1111);
            chk("hold_reg2",  a_reg2,          32'h2222);
            chk("hold_aluop", 32'(a_aluop),    32'h25);
        end
        ex_ready_i = 1'b1;
        #1;
        chk("release_ready", 32'(a_id_ready), 32'h1);
        tick();
        chk("release_wd",   32'(a_wd), 32'h7);
        chk("release_reg2", a_reg2,    32'h1);

        // flush while held, incoming instruction dropped
        ex_ready_i = 1'b0; flush_i = 1'b1;
        inst_i = itype(6'b001101, 5'd1, 5'd8, 16'h0002);
        tick();
        chk("flush_valid", 32'(a_ex_valid), 32'h0);
        chk("flush_wreg",  32'(a_wreg),     32'h0);
        flush_i = 1'b0; ex_ready_i = 1'b1;

        // illegal opcode 0x3F
        inst_i = 32'hFC00_0000;
        tick();
        chk("ill_valid", 32'(a_ex_valid),  32'h1);
        chk("ill_instv", 32'(a_instvalid), 32'h0);
        chk("ill_wreg",  32'(a_wreg),      32'h0);
        chk("ill_aluop", 32'(a_aluop),     32'h0);

        // no instruction offered: bubble
        inst_valid_i = 1'b0;
        tick();
        chk("idle_valid", 32'(a_ex_valid), 32'h0);

        // reset in the middle of a hold
        inst_valid_i = 1'b1;
        inst_i = itype(6'b001101, 5'd1, 5'd2, 16'h00FF);
        tick();
        ex_ready_i = 1'b0;
        tick();
        chk("pre_rst_valid", 32'(a_ex_valid), 32'h1);
        rst = 1'b0;
        tick();
        chk_reset_a("midrst");
        rst = 1'b1; ex_ready_i = 1'b1;
        tick();
        chk("post_rst_valid", 32'(a_ex_valid), 32'h1);
        chk("post_rst_wd",    32'(a_wd),       32'h2);

        // no-forwarding variant stalls on a MEM write to $1
        inst_i = rtype(5'd1, 5'd2, 5'd3, 5'd0, 6'h25);
        mem_wreg_i = 1'b1; mem_wd_i = 5'd1; mem_wdata_i = 32'hB;
        #1;
        chk("nf_ready",     32'(b_id_ready), 32'h0);
        chk("fwd_no_stall", 32'(a_id_ready), 32'h1);
        tick();
        chk("nf_bubble1", 32'(b_ex_valid), 32'h0);
        chk("nf_ready2",  32'(b_id_ready), 32'h0);
        tick();
        chk("nf_bubble2", 32'(b_ex_valid), 32'h0);
        mem_wreg_i = 1'b0;
        #1;
        chk("nf_clear_ready", 32'(b_id_ready), 32'h1);
        tick();
        chk("nf_issue_valid", 32'(b_ex_valid), 32'h1);
        chk("nf_issue_wd",    32'(b_wd),       32'h3);
        chk("nf_issue_reg1",  b_reg1,          32'h1111);

        // $0 never hazard-matches
        inst_i = rtype(5'd0, 5'd0, 5'd3, 5'd0, 6'h25);
        mem_wreg_i = 1'b1; mem_wd_i = 5'd0;
        #1;
        chk("nf_zero_ready", 32'(b_id_ready), 32'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
